// File: rtl/conversor_sinal_bcd_pkg.sv
// Shared definitions for the signed/unsigned BCD display path:
// FSM states, default widths and double-dabble nibble constants.
package conversor_sinal_bcd_pkg;

  typedef enum logic [1:0] {
    OCIOSO   = 2'd0,
    CONVERTE = 2'd1,
    FIM      = 2'd2
  } estado_t;

  localparam int unsigned LARGURA_PADRAO = 8;
  localparam int unsigned DIGITOS_PADRAO = 3;

  localparam logic [3:0] LIMIAR_AJUSTE = 4'd5;
  localparam logic [3:0] AJUSTE        = 4'd3;

endpackage

// File: rtl/conversor_sinal_bcd_ajuste_add3.sv
// Double-dabble digit correction: nibbles of 5 or more get +3 before the shift.
module ajuste_add3
  import conversor_sinal_bcd_pkg::*;
(
  input  logic [3:0] entrada_i,
  output logic [3:0] saida_o
);

  always_comb begin
    saida_o = entrada_i;
    if (entrada_i >= LIMIAR_AJUSTE) begin
      saida_o = entrada_i + AJUSTE;
    end
  end

endmodule

// File: rtl/conversor_sinal_bcd.sv
// Sign/magnitude BCD converter for the adder result, one double-dabble bit per clock,
// with start/busy/done handshake; outputs change only on completion.
module conversor_sinal_bcd
  import conversor_sinal_bcd_pkg::*;
#(
  parameter int unsigned LARGURA = LARGURA_PADRAO,
  parameter int unsigned DIGITOS = DIGITOS_PADRAO
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   inicio,
  input  logic [LARGURA-1:0]     entrada,
  input  logic                   com_sinal,
  output logic                   ocupado,
  output logic                   pronto,
  output logic                   negativo,
  output logic [4*DIGITOS-1:0]   bcd
);

  localparam int unsigned CW = (LARGURA > 1) ? $clog2(LARGURA) : 1;
  localparam int unsigned BW = 4 * DIGITOS;

  estado_t            estado_q, estado_d;
  logic [LARGURA-1:0] mag_q, mag_d;
  logic [BW-1:0]      scratch_q, scratch_d;
  logic [CW-1:0]      contador_q, contador_d;
  logic               neg_int_q, neg_int_d;
  logic [BW-1:0]      bcd_q, bcd_d;
  logic               negativo_q, negativo_d;

  logic [BW-1:0]      ajustado;
  logic [BW-1:0]      scratch_desloc;
  logic               aceita_neg;

  for (genvar g = 0; g < DIGITOS; g++) begin : g_ajuste
    ajuste_add3 u_ajuste (
      .entrada_i (scratch_q[4*g +: 4]),
      .saida_o   (ajustado[4*g +: 4])
    );
  end

  assign scratch_desloc = {ajustado[BW-2:0], mag_q[LARGURA-1]};
  assign aceita_neg     = com_sinal & entrada[LARGURA-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      estado_q   <= OCIOSO;
      mag_q      <= '0;
      scratch_q  <= '0;
      contador_q <= '0;
      neg_int_q  <= 1'b0;
      bcd_q      <= '0;
      negativo_q <= 1'b0;
    end else begin
      estado_q   <= estado_d;
      mag_q      <= mag_d;
      scratch_q  <= scratch_d;
      contador_q <= contador_d;
      neg_int_q  <= neg_int_d;
      bcd_q      <= bcd_d;
      negativo_q <= negativo_d;
    end
  end

  always_comb begin
    estado_d   = estado_q;
    mag_d      = mag_q;
    scratch_d  = scratch_q;
    contador_d = contador_q;
    neg_int_d  = neg_int_q;
    bcd_d      = bcd_q;
    negativo_d = negativo_q;

    case (estado_q)
      OCIOSO: begin
        if (inicio) begin
          // Most-negative input negates to itself, which read unsigned is 2^(LARGURA-1).
          mag_d      = aceita_neg ? (-entrada) : entrada;
          neg_int_d  = aceita_neg;
          scratch_d  = '0;
          contador_d = '0;
          estado_d   = CONVERTE;
        end
      end
      CONVERTE: begin
        scratch_d  = scratch_desloc;
        mag_d      = mag_q << 1;
        contador_d = contador_q + CW'(1);
        if (contador_q == CW'(LARGURA - 1)) begin
          bcd_d      = scratch_desloc;
          negativo_d = neg_int_q;
          estado_d   = FIM;
        end
      end
      FIM: begin
        estado_d = OCIOSO;
      end
      default: begin
        estado_d = OCIOSO;
      end
    endcase
  end

  assign ocupado  = (estado_q != OCIOSO);
  assign pronto   = (estado_q == FIM);
  assign negativo = negativo_q;
  assign bcd      = bcd_q;

endmodule

// File: tb/tb_conversor_sinal_bcd.sv
// Directed bench for conversor_sinal_bcd: hand-computed BCD/sign results, latency,
// busy handling and mid-conversion reset.
module tb_conversor_sinal_bcd;

  logic        clk;
  logic        rst;
  logic        inicio;
  logic [7:0]  entrada;
  logic        com_sinal;
  logic        ocupado;
  logic        pronto;
  logic        negativo;
  logic [11:0] bcd;

  int unsigned total;
  int unsigned passes;
  int unsigned fails;
  int unsigned cyc;
  int unsigned pulsos;
  logic [11:0] bcd_ant;

  conversor_sinal_bcd #(
    .LARGURA (8),
    .DIGITOS (3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .inicio    (inicio),
    .entrada   (entrada),
    .com_sinal (com_sinal),
    .ocupado   (ocupado),
    .pronto    (pronto),
    .negativo  (negativo),
    .bcd       (bcd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for pronto, starting from the negedge right after acceptance.
  task automatic espera_pronto(input string tag);
    cyc = 0;
    while (pronto !== 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (cyc == 4) check({tag, "_hold"}, {20'd0, bcd}, {20'd0, bcd_ant});
    end
    check({tag, "_lat"}, cyc, 8);
  endtask

  task automatic converte(input logic [7:0] val, input logic sinal,
                          input logic [11:0] eb, input logic en, input string tag);
    @(negedge clk);
    entrada   = val;
    com_sinal = sinal;
    inicio    = 1'b1;
    @(negedge clk);
    inicio    = 1'b0;
    entrada   = ~val;
    com_sinal = ~sinal;
    check({tag, "_ocup"}, {31'd0, ocupado}, 1);
    espera_pronto(tag);
    check({tag, "_bcd"}, {20'd0, bcd}, {20'd0, eb});
    check({tag, "_neg"}, {31'd0, negativo}, {31'd0, en});
    @(negedge clk);
    check({tag, "_pulso"}, {31'd0, pronto}, 0);
    check({tag, "_livre"}, {31'd0, ocupado}, 0);
    check({tag, "_mantem"}, {19'd0, negativo, bcd}, {19'd0, en, eb});
    bcd_ant = eb;
  endtask

  initial begin
    total = 0; passes = 0; fails = 0; bcd_ant = '0;
    rst = 1'b1; inicio = 1'b0; entrada = '0; com_sinal = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_ocup", {31'd0, ocupado}, 0);
    check("rst_pronto", {31'd0, pronto}, 0);
    check("rst_out", {19'd0, negativo, bcd}, 0);
    rst = 1'b0;

    converte(8'hFF, 1'b0, 12'h255, 1'b0, "u_ff");
    converte(8'hFF, 1'b1, 12'h001, 1'b1, "s_m1");
    converte(8'h80, 1'b1, 12'h128, 1'b1, "s_80");
    converte(8'h7F, 1'b1, 12'h127, 1'b0, "s_7f");
    converte(8'h00, 1'b1, 12'h000, 1'b0, "s_00");
    converte(8'h80, 1'b0, 12'h128, 1'b0, "u_80");

    // inicio held high through the whole conversion
    @(negedge clk);
    entrada = 8'h05; com_sinal = 1'b0; inicio = 1'b1;
    @(negedge clk);
    entrada = 8'h09;
    espera_pronto("busy1");
    check("busy1_bcd", {20'd0, bcd}, 12'h005);
    @(negedge clk);
    check("busy_fim_livre", {31'd0, ocupado}, 0);
    @(negedge clk);
    inicio = 1'b0;
    check("busy2_aceito", {31'd0, ocupado}, 1);
    bcd_ant = 12'h005;
    espera_pronto("busy2");
    check("busy2_bcd", {20'd0, bcd}, 12'h009);
    bcd_ant = 12'h009;

    converte(8'h80, 1'b1, 12'h128, 1'b1, "pre_rst");

    // reset in the middle of a conversion
    @(negedge clk);
    entrada = 8'hC8; com_sinal = 1'b1; inicio = 1'b1;
    @(negedge clk);
    inicio = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_ocup", {31'd0, ocupado}, 0);
    check("midrst_pronto", {31'd0, pronto}, 0);
    check("midrst_out", {19'd0, negativo, bcd}, 0);
    pulsos = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (pronto === 1'b1) pulsos++;
    end
    check("midrst_sem_pronto", pulsos, 0);
    bcd_ant = 12'h000;
    converte(8'hC8, 1'b1, 12'h056, 1'b1, "s_c8");

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
